// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and its environment.
// Optional PAUSE_EN adds the pause button input.
interface game_sequencer_if;
  logic       start;
  logic       block_hit;
  logic       floor_hit;
`ifdef PAUSE_EN
  logic       pause;
`endif
  logic       run;
  logic       serve;
  logic       clear_blocks;
  logic [1:0] lives;
  logic [9:0] score;
  logic [5:0] blocks_left;
  logic [2:0] state;

  modport master (
`ifdef PAUSE_EN
    output pause,
`endif
    output start, block_hit, floor_hit,
    input  run, serve, clear_blocks, lives, score, blocks_left, state
  );

  modport slave (
`ifdef PAUSE_EN
    input  pause,
`endif
    input  start, block_hit, floor_hit,
    output run, serve, clear_blocks, lives, score, blocks_left, state
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: idle/serve/play/lost/over/win sequencing,
// lives/score/bricks bookkeeping, registered datapath controls.
// Optional feature macro PAUSE_EN: adds pause button and PAUSED state (6).
module game_sequencer #(
  parameter int LIVES       = 3,
  parameter int NUM_BLOCKS  = 60,
  parameter int SERVE_DELAY = 64
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave gif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    LOST   = 3'd3,
    OVER   = 3'd4,
    WIN    = 3'd5,
    PAUSED = 3'd6
  } state_t;

  state_t     st, st_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] lives_r, lives_n;
  logic [9:0] score_r, score_n;
  logic [5:0] blk_r, blk_n;
  logic       run_r, serve_r, serve_n, clr_r, clr_n;
  logic       start_q, start_edge;
  logic       won;

  assign start_edge = gif.start & ~start_q;

`ifdef PAUSE_EN
  logic pause_q, pause_edge;
  assign pause_edge = gif.pause & ~pause_q;

  // Pause button edge detector; held-at-reset press does not count.
  always_ff @(posedge clk) begin
    if (rst) pause_q <= 1'b1;
    else     pause_q <= gif.pause;
  end
`endif

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    lives_n = lives_r;
    score_n = score_r;
    blk_n   = blk_r;
    serve_n = 1'b0;
    clr_n   = 1'b0;
    won     = 1'b0;
    case (st)
      IDLE, OVER, WIN: begin
        if (start_edge) begin
          st_n    = SERVE;
          cnt_n   = '0;
          lives_n = 2'(LIVES);
          score_n = '0;
          blk_n   = 6'(NUM_BLOCKS);
          serve_n = 1'b1;
          clr_n   = 1'b1;
        end
      end
      SERVE: begin
        if (cnt == 8'(SERVE_DELAY - 1)) begin
          st_n  = PLAY;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      PLAY: begin
`ifdef PAUSE_EN
        if (pause_edge) begin
          st_n = PAUSED;
        end else
`endif
        begin
          // The brick is counted before the floor so a last-brick hit wins.
          if (gif.block_hit) begin
            if (score_r != 10'd1023) score_n = score_r + 10'd1;
            blk_n = blk_r - 6'd1;
            if (blk_r == 6'd1) begin
              won  = 1'b1;
              st_n = WIN;
            end
          end
          if (gif.floor_hit && !won) begin
            lives_n = lives_r - 2'd1;
            cnt_n   = '0;
            st_n    = (lives_r == 2'd1) ? OVER : LOST;
          end
        end
      end
      LOST: begin
        if (cnt == 8'(SERVE_DELAY - 1)) begin
          st_n    = SERVE;
          cnt_n   = '0;
          serve_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
`ifdef PAUSE_EN
      PAUSED: begin
        if (pause_edge) st_n = PLAY;
      end
`endif
      default: st_n = IDLE;
    endcase
  end

  // State and output registers; reset drops any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      lives_r <= 2'(LIVES);
      score_r <= '0;
      blk_r   <= 6'(NUM_BLOCKS);
      run_r   <= 1'b0;
      serve_r <= 1'b0;
      clr_r   <= 1'b0;
      start_q <= 1'b1;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      lives_r <= lives_n;
      score_r <= score_n;
      blk_r   <= blk_n;
      run_r   <= (st_n == PLAY);
      serve_r <= serve_n;
      clr_r   <= clr_n;
      start_q <= gif.start;
    end
  end

  assign gif.state        = st;
  assign gif.run          = run_r;
  assign gif.serve        = serve_r;
  assign gif.clear_blocks = clr_r;
  assign gif.lives        = lives_r;
  assign gif.score        = score_r;
  assign gif.blocks_left  = blk_r;

endmodule
